// File: rtl/inst_fetch.sv
// RV32I instruction fetch: PC, single-outstanding imem req/ack, registered instruction with imm_sel pre-decode.
// Optional macro FETCH_MISALIGN_CHECK_EN rejects redirects whose target is not word aligned.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [2:0]  imm_sel,
    output logic        illegal_op,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        redirect_eff;
    logic [31:0] target_al;
    logic [3:0]  dec_p0;

    // {illegal, imm_sel} from the major opcode
    function automatic logic [3:0] decode_imm(input logic [6:0] opc);
        logic [3:0] r;
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111: r = 4'b0_000;
            7'b0100011:                         r = 4'b0_001;
            7'b1100011:                         r = 4'b0_010;
            7'b0110111, 7'b0010111:             r = 4'b0_011;
            7'b1101111:                         r = 4'b0_100;
            7'b0110011:                         r = 4'b0_000;
            default:                            r = 4'b1_000;
        endcase
        return r;
    endfunction

    assign target_al = {redirect_target[31:2], 2'b00};
    assign dec_p0    = decode_imm(imem_rdata[6:0]);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_eff = redirect && (redirect_target[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else
            misalign_err <= redirect && (redirect_target[1:0] != 2'b00);
    end
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^redirect_target[1:0];
    assign redirect_eff   = redirect;
    assign misalign_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= NOP;
            pc_out     <= RESET_PC;
            imm_sel    <= 3'b000;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect_eff) begin
                        pc        <= target_al;
                        imem_addr <= target_al;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                REQ: begin
                    // imem_addr stays on the outstanding request even when pc moves
                    if (redirect_eff)
                        pc <= target_al;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (kill || redirect_eff) begin
                            kill  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            inst_out   <= imem_rdata;
                            pc_out     <= imem_addr;
                            imm_sel    <= dec_p0[2:0];
                            illegal_op <= dec_p0[3];
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (redirect_eff) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_eff) begin
                        pc         <= target_al;
                        imem_addr  <= target_al;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        pc         <= pc + 32'd4;
                        imem_addr  <= pc + 32'd4;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: random memory latency, ready and redirects against a fetch-order model.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MCHK = 1'b1;
`else
    localparam bit MCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [2:0]  imm_sel;
    logic        illegal_op;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misalign_err;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .pc_out(pc_out),
        .imm_sel(imm_sel), .illegal_op(illegal_op),
        .redirect(redirect), .redirect_target(redirect_target),
        .misalign_err(misalign_err)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference immediate-format table: {illegal, imm_sel}
    function automatic logic [3:0] ref_dec(input logic [31:0] w);
        case (w[6:0])
            7'h03, 7'h13, 7'h67: return 4'h0;
            7'h23:               return 4'h1;
            7'h63:               return 4'h2;
            7'h37, 7'h17:        return 4'h3;
            7'h6F:               return 4'h4;
            7'h33:               return 4'h0;
            default:             return 4'h8;
        endcase
    endfunction

    // Memory model
    logic [31:0] mem [64];
    bit          in_req;
    int          mdelay;
    int          fixed_delay;

    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit rdy);
        @(posedge clk);
        #1;
        if (imem_ack) begin
            imem_ack = 1'b0;
            in_req   = 1'b0;
        end
        imem_rdata = $urandom;
        if (imem_req && !in_req) begin
            in_req = 1'b1;
            mdelay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (in_req && imem_req) begin
            if (mdelay == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[7:2]];
            end else begin
                mdelay--;
            end
        end
        redirect        = rd;
        redirect_target = tgt;
        inst_ready      = rdy;
    endtask

    // Scoreboard / monitor
    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] exp_pc;
    logic [31:0] req_addr;
    logic [31:0] prev_inst, prev_pcout;
    logic [2:0]  prev_sel;
    logic        prev_ill;
    bit          req_void, prev_req, pushed_last, prev_valid, prev_leave, exp_merr;
    bit          eff, mis, hs, push;
    int          idle_cnt;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc      = RPC;
            req_void    = 1'b0;
            prev_req    = 1'b0;
            pushed_last = 1'b0;
            prev_valid  = 1'b0;
            prev_leave  = 1'b0;
            exp_merr    = 1'b0;
            idle_cnt    = 0;
            q.delete();
        end else begin
            check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_merr});
            if (pushed_last)
                check("fetch_latency", {31'b0, inst_valid}, 32'd1);
            if (inst_valid && !prev_valid) begin
                idle_cnt = 0;
                if (q.size() == 0) begin
                    check("spurious_valid", {31'b0, inst_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("inst_out", inst_out, e.word);
                    check("pc_out", pc_out, e.addr);
                    check("imm_sel", {29'b0, imm_sel}, {29'b0, ref_dec(e.word)[2:0]});
                    check("illegal_op", {31'b0, illegal_op}, {31'b0, ref_dec(e.word)[3]});
                end
            end
            if (prev_valid && !prev_leave) begin
                check("hold_valid", {31'b0, inst_valid}, 32'd1);
                check("hold_inst", inst_out, prev_inst);
                check("hold_pc", pc_out, prev_pcout);
                check("hold_sel", {29'b0, imm_sel}, {29'b0, prev_sel});
                check("hold_ill", {31'b0, illegal_op}, {31'b0, prev_ill});
            end
            if (prev_valid && prev_leave)
                check("valid_drop", {31'b0, inst_valid}, 32'd0);
            if (inst_valid)
                check("req_while_valid", {31'b0, imem_req}, 32'd0);

            if (imem_req && !prev_req) begin
                check("fetch_addr", imem_addr, exp_pc);
                req_addr = imem_addr;
                req_void = 1'b0;
            end else if (imem_req) begin
                check("addr_stable", imem_addr, req_addr);
            end

            // what the next rising edge will do
            mis  = redirect && MCHK && (redirect_target[1:0] != 2'b00);
            eff  = redirect && !mis;
            hs   = inst_valid && inst_ready && !eff;
            push = 1'b0;
            if (eff) begin
                exp_pc   = redirect_target & 32'hFFFF_FFFC;
                req_void = 1'b1;
            end else if (hs) begin
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req && imem_ack && !req_void) begin
                q.push_back('{req_addr, imem_rdata});
                push = 1'b1;
            end

            idle_cnt++;
            if (idle_cnt == 100)
                check("fetch_progress_timeout", idle_cnt, 32'd0);

            pushed_last = push;
            prev_valid  = inst_valid;
            prev_leave  = inst_valid && (hs || eff);
            prev_inst   = inst_out;
            prev_pcout  = pc_out;
            prev_sel    = imm_sel;
            prev_ill    = illegal_op;
            prev_req    = imem_req;
            exp_merr    = mis;
        end
    end

    // Stimulus
    logic [6:0] opcs [10];
    logic [31:0] tgt;

    initial begin
        opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        for (int i = 0; i < 64; i++)
            mem[i] = {$urandom} & 32'hFFFF_FF80 | {25'b0, opcs[$urandom_range(0, 9)]};
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00C0_006F;
        mem[2] = 32'hFE00_0EE3;
        mem[3] = 32'h1234_5037;
        mem[4] = 32'hFFFF_FFFF;

        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0;
        in_req = 1'b0; mdelay = 0; fixed_delay = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_out", inst_out, 32'h0000_0013);
        check("rst_pc_out", pc_out, RPC);
        check("rst_imem_addr", imem_addr, RPC);
        check("rst_imm_sel", {29'b0, imm_sel}, 32'd0);
        check("rst_illegal", {31'b0, illegal_op}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        rst = 1'b0;

        // zero-wait memory, decode stalls 5+ cycles on the first word
        repeat (8) cycle(1'b0, 32'h0, 1'b0);
        repeat (12) cycle(1'b0, 32'h0, 1'b1);

        // redirect while the response is delayed by 3 cycles
        fixed_delay = 3;
        for (int i = 0; i < 20 && !(imem_req && !imem_ack); i++) cycle(1'b0, 32'h0, 1'b1);
        check("wait_req", {31'b0, imem_req}, 32'd1);
        cycle(1'b1, 32'h200, 1'b1);
        repeat (12) cycle(1'b0, 32'h0, 1'b1);

        // misaligned redirect while an instruction is held
        fixed_delay = -1;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle(1'b0, 32'h0, 1'b0);
        check("wait_valid", {31'b0, inst_valid}, 32'd1);
        cycle(1'b1, 32'h202, 1'b0);
        repeat (12) cycle(1'b0, 32'h0, 1'b1);

        // random traffic, including targets near the top of the address space
        for (int n = 0; n < 600; n++) begin
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 4) == 0)
                tgt[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 99) < 8, tgt, $urandom_range(0, 3) != 0);
        end

        // asynchronous reset while a request is outstanding
        fixed_delay = 2;
        for (int i = 0; i < 20 && !imem_req; i++) cycle(1'b0, 32'h0, 1'b1);
        check("wait_req_rst", {31'b0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        imem_ack = 1'b0;
        in_req = 1'b0;
        redirect = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'd0);
        check("async_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("async_rst_pc_out", pc_out, RPC);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fixed_delay = -1;
        repeat (40) cycle(1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
